sdram_avalon_bridge: RTL and testbench
======================================

# sdram_avalon_bridge

Single-outstanding-transaction bridge between the custom-logic SDRAM request port and the Avalon-MM master port of the SDRAM controller. It sits directly downstream of the custom-logic top level. It consumes that block's read enable, write enable, 26-bit word address and 32-bit write data, and returns the registered read data and a one-cycle read-valid pulse that feed its SDRAM data input. It handles waitrequest back-pressure, variable read latency and a bounded timeout.

## Interface
Parameters:
- TIMEOUT, 256: maximum cycles a transaction may spend outside IDLE before it is aborted (legal range 4..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  reset; one clock; reset is synchronous and active-low
- req_read_en  in  1  read request from custom logic
- req_write_en  in  1  write request from custom logic
- req_address  in  26  word address of the request
- req_writedata  in  32  write data
- req_readdata  out  32  read data returned to custom logic (its SDRAM data input)
- req_readvalid  out  1  one-cycle pulse; req_readdata is valid in this cycle
- req_write_done  out  1  one-cycle pulse; write accepted by the controller
- req_busy  out  1  high whenever state is not IDLE
- err_flag  out  1  sticky protocol/timeout error; cleared only by reset
- avm_address  out  28  byte address = {captured address, 2'b00}
- avm_read  out  1  Avalon read command
- avm_write  out  1  Avalon write command
- avm_writedata  out  32  captured write data
- avm_byteenable  out  4  constant 4'b1111 while a command is asserted, else 0
- avm_waitrequest  in  1  controller stall
- avm_readdata  in  32  controller read data
- avm_readdatavalid  in  1  controller read-data strobe

## Operation
- All outputs are registered. Reset value of every output is 0.
- States: IDLE, RD_CMD, RD_WAIT, WR_CMD.
- IDLE:
  - req_read_en=1: capture address, go RD_CMD.
  - req_write_en=1 (read low): capture address and data, go WR_CMD.
  - Both high: read serviced, write dropped, err_flag set.
- RD_CMD: avm_read=1 and avm_address held stable. When avm_waitrequest=0, drop avm_read and go RD_WAIT. avm_readdatavalid is ignored in this state.
- RD_WAIT: on avm_readdatavalid=1, register avm_readdata into req_readdata, pulse req_readvalid, go IDLE.
- WR_CMD: avm_write=1 with address and data held stable. When avm_waitrequest=0, drop avm_write, pulse req_write_done, go IDLE.
- Requests arriving while req_busy=1 are ignored and set err_flag. A request held high across the IDLE return is treated as a new request.
- avm_readdatavalid seen in IDLE or WR_CMD is discarded and sets err_flag.
- Timeout counter (16 bits):
  - Cleared on leaving IDLE; increments every non-IDLE cycle.
  - When it reaches TIMEOUT-1 without completion, the transaction is aborted: avm_read/avm_write drop, err_flag sets, state returns to IDLE.
  - Aborted read: req_readdata=32'hDEADBEEF with a req_readvalid pulse.
  - Aborted write: req_write_done pulse.
  - Completion in the same cycle as the timeout takes priority; no error is raised.
- req_readdata holds its last value between pulses.

## Timing
- Request sampled at edge t. avm_read/avm_write are high from t+1.
- Zero-wait write: req_write_done high in cycle t+2.
- Read with readdatavalid in cycle r (r ≥ t+2): req_readvalid and data high in cycle r+1. Minimum read latency is 3 cycles.
- Back-to-back requests: the next request is accepted in the cycle req_readvalid or req_write_done is high (state is IDLE then). Throughput is at most one transaction per 2 cycles.
- n_rst low at any edge: state IDLE, counter 0, all outputs 0 on that edge. Commands drop even mid-waitrequest. err_flag clears.

## Test plan
- Reset with avm_read mid-stall: assert read to addr 26'h0000010 with waitrequest=1, then n_rst=0 -> avm_read=0 and req_busy=0 after that edge, err_flag=0.
- Single read: addr 26'h0000010, waitrequest held 2 cycles, readdatavalid 3 cycles after acceptance with 32'hA5A5_1234 -> avm_address=28'h0000040; req_readvalid pulses exactly once with 32'hA5A5_1234; err_flag=0.
- Write with stall: addr 26'h3FFFFFF, data 32'h0BAD_F00D, waitrequest=1 for 5 cycles -> avm_write held 6 cycles with stable address/data, byteenable 4'hF, then req_write_done pulses once.
- Simultaneous read+write in IDLE -> only avm_read issued; err_flag=1 and stays 1; no avm_write ever asserted.
- Timeout with TIMEOUT=8, readdatavalid never asserted -> req_readvalid with 32'hDEADBEEF in the 8th non-IDLE cycle; err_flag=1; next request serviced normally.
- Stray avm_readdatavalid in IDLE with 32'h1111_1111 -> req_readvalid stays 0, req_readdata unchanged, err_flag=1.

Source files
------------

// File: rtl/sdram_avalon_bridge.sv
// Single-outstanding bridge from the custom-logic SDRAM request port to an
// Avalon-MM master: waitrequest stalls, variable read latency, bounded timeout.
module sdram_avalon_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_read_en,
  input  logic        req_write_en,
  input  logic [25:0] req_address,
  input  logic [31:0] req_writedata,
  output logic [31:0] req_readdata,
  output logic        req_readvalid,
  output logic        req_write_done,
  output logic        req_busy,
  output logic        err_flag,
  output logic [27:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

  // The counter holds 0 in the first busy cycle, so aborting when it shows
  // TIMEOUT-2 makes the abort pulse land TIMEOUT cycles after acceptance.
  localparam logic [15:0] ABORT_CNT = 16'(TIMEOUT - 2);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [25:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        wdone_q, wdone_d;
  logic        err_q, err_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        busy_q, busy_d;
  logic [3:0]  be_q, be_d;
  logic        expired;

  assign expired = (count_q >= ABORT_CNT);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + 16'd1;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = err_q;

    if (state_q != IDLE && (req_read_en || req_write_en)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (avm_readdatavalid) err_d = 1'b1;
        if (req_read_en) begin
          addr_d  = req_address;
          state_d = RD_CMD;
          if (req_write_en) err_d = 1'b1;
        end else if (req_write_en) begin
          addr_d  = req_address;
          wdata_d = req_writedata;
          state_d = WR_CMD;
        end
      end
      RD_CMD: begin
        if (expired) begin
          rdata_d  = 32'hDEADBEEF;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else if (!avm_waitrequest) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d  = avm_readdata;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (expired) begin
          rdata_d  = 32'hDEADBEEF;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      WR_CMD: begin
        if (avm_readdatavalid) err_d = 1'b1;
        // Acceptance on the timeout edge still counts as a clean completion.
        if (!avm_waitrequest) begin
          wdone_d = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          wdone_d = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    read_d  = (state_d == RD_CMD);
    write_d = (state_d == WR_CMD);
    busy_d  = (state_d != IDLE);
    be_d    = (read_d || write_d) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      be_q     <= 4'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
      read_q   <= read_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      be_q     <= be_d;
    end
  end

  assign req_readdata   = rdata_q;
  assign req_readvalid  = rvalid_q;
  assign req_write_done = wdone_q;
  assign req_busy       = busy_q;
  assign err_flag       = err_q;
  assign avm_address    = {addr_q, 2'b00};
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule

// File: tb/tb_sdram_avalon_bridge.sv
// Bench for sdram_avalon_bridge: transaction-age reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_sdram_avalon_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_read_en, req_write_en;
  logic [25:0] req_address;
  logic [31:0] req_writedata;
  logic [31:0] req_readdata;
  logic        req_readvalid, req_write_done, req_busy, err_flag;
  logic [27:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  always #5 clk = ~clk;

  sdram_avalon_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_read_en(req_read_en), .req_write_en(req_write_en),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_readvalid(req_readvalid),
    .req_write_done(req_write_done), .req_busy(req_busy), .err_flag(err_flag),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction tracked by kind and age in edges.
  logic        m_active = 1'b0, m_is_read = 1'b0, m_cmd_acc = 1'b0;
  int          m_age = 0;
  logic [25:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  logic        m_rv = 1'b0, m_wd = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_active = 1'b0; m_is_read = 1'b0; m_cmd_acc = 1'b0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_rv = 1'b0; m_wd = 1'b0; m_err = 1'b0;
    end else begin
      m_rv = 1'b0;
      m_wd = 1'b0;
      if (m_active) begin
        m_age = m_age + 1;
        if (req_read_en || req_write_en) m_err = 1'b1;
        if (!m_is_read) begin
          if (avm_readdatavalid) m_err = 1'b1;
          if (!avm_waitrequest) begin
            m_wd = 1'b1; m_active = 1'b0;
          end else if (m_age == TO - 1) begin
            m_wd = 1'b1; m_err = 1'b1; m_active = 1'b0;
          end
        end else if (!m_cmd_acc) begin
          if (m_age == TO - 1) begin
            m_rv = 1'b1; m_rdata = 32'hDEADBEEF; m_err = 1'b1; m_active = 1'b0;
          end else if (!avm_waitrequest) begin
            m_cmd_acc = 1'b1;
          end
        end else if (avm_readdatavalid) begin
          m_rv = 1'b1; m_rdata = avm_readdata; m_active = 1'b0;
        end else if (m_age == TO - 1) begin
          m_rv = 1'b1; m_rdata = 32'hDEADBEEF; m_err = 1'b1; m_active = 1'b0;
        end
      end else begin
        if (avm_readdatavalid) m_err = 1'b1;
        if (req_read_en) begin
          m_active = 1'b1; m_is_read = 1'b1; m_cmd_acc = 1'b0; m_age = 0;
          m_addr = req_address;
          if (req_write_en) m_err = 1'b1;
        end else if (req_write_en) begin
          m_active = 1'b1; m_is_read = 1'b0; m_cmd_acc = 1'b0; m_age = 0;
          m_addr = req_address; m_wdata = req_writedata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_rd, e_wr;
      e_rd = m_active && m_is_read && !m_cmd_acc;
      e_wr = m_active && !m_is_read;
      check("avm_read",       32'(avm_read),       32'(e_rd));
      check("avm_write",      32'(avm_write),      32'(e_wr));
      check("avm_address",    32'(avm_address),    32'({m_addr, 2'b00}));
      check("avm_writedata",  avm_writedata,       m_wdata);
      check("avm_byteenable", 32'(avm_byteenable), (e_rd || e_wr) ? 32'hF : 32'h0);
      check("req_busy",       32'(req_busy),       32'(m_active));
      check("req_readvalid",  32'(req_readvalid),  32'(m_rv));
      check("req_readdata",   req_readdata,        m_rdata);
      check("req_write_done", 32'(req_write_done), 32'(m_wd));
      check("err_flag",       32'(err_flag),       32'(m_err));
    end
  end

  // Event counters sampled on the rising edge (they see the cycle just ended).
  int rv_pulses = 0, wd_pulses = 0, wr_cycles = 0;
  always @(posedge clk) begin
    if (req_readvalid === 1'b1)  rv_pulses++;
    if (req_write_done === 1'b1) wd_pulses++;
    if (avm_write === 1'b1)      wr_cycles++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
  endtask

  initial begin
    int rv0, wd0, wc0, lat;
    n_rst = 1'b0; req_read_en = 1'b0; req_write_en = 1'b0;
    req_address = '0; req_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    steps(3);
    cmp_en = 1'b1;
    check("reset_busy", 32'(req_busy), 32'h0);
    check("reset_err", 32'(err_flag), 32'h0);
    n_rst = 1'b1;

    // Reset while a read command is stalled.
    req_read_en = 1'b1; req_address = 26'h0000010; avm_waitrequest = 1'b1;
    step();
    req_read_en = 1'b0;
    check("stall_read_up", 32'(avm_read), 32'h1);
    n_rst = 1'b0;
    step();
    check("rst_read_drop", 32'(avm_read), 32'h0);
    check("rst_busy_drop", 32'(req_busy), 32'h0);
    check("rst_err_clear", 32'(err_flag), 32'h0);
    n_rst = 1'b1; avm_waitrequest = 1'b0;
    step();

    // Single read: two stall cycles, data three cycles after command acceptance.
    rv0 = rv_pulses;
    req_read_en = 1'b1; req_address = 26'h0000010; avm_waitrequest = 1'b1;
    step();
    req_read_en = 1'b0;
    check("rd_addr", 32'(avm_address), 32'h0000040);
    steps(2);
    avm_waitrequest = 1'b0;
    step();
    avm_waitrequest = 1'b1;
    steps(2);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A5_1234;
    step();
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    check("rd_valid", 32'(req_readvalid), 32'h1);
    check("rd_data", req_readdata, 32'hA5A5_1234);
    steps(2);
    check("rd_pulse_count", 32'(rv_pulses - rv0), 32'h1);
    check("rd_err", 32'(err_flag), 32'h0);

    // Write stalled for 5 cycles, then a back-to-back minimum-latency read.
    wc0 = wr_cycles; wd0 = wd_pulses;
    req_write_en = 1'b1; req_address = 26'h3FFFFFF; req_writedata = 32'h0BAD_F00D;
    avm_waitrequest = 1'b1;
    step();
    req_write_en = 1'b0;
    check("wr_addr", 32'(avm_address), 32'h0FFFFFFC);
    check("wr_be", 32'(avm_byteenable), 32'hF);
    check("wr_data", avm_writedata, 32'h0BAD_F00D);
    steps(5);
    avm_waitrequest = 1'b0;
    step();
    check("wr_done", 32'(req_write_done), 32'h1);
    req_read_en = 1'b1; req_address = 26'h0000123;
    step();
    req_read_en = 1'b0;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_0001;
    step();
    avm_readdatavalid = 1'b0;
    check("b2b_valid", 32'(req_readvalid), 32'h1);
    check("b2b_data", req_readdata, 32'hCAFE_0001);
    steps(2);
    check("wr_cycles", 32'(wr_cycles - wc0), 32'd6);
    check("wr_done_count", 32'(wd_pulses - wd0), 32'h1);
    check("b2b_err", 32'(err_flag), 32'h0);

    // Stray readdatavalid while idle.
    rv0 = rv_pulses;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1111_1111;
    step();
    avm_readdatavalid = 1'b0;
    steps(2);
    check("stray_no_valid", 32'(rv_pulses - rv0), 32'h0);
    check("stray_data_held", req_readdata, 32'hCAFE_0001);
    check("stray_err", 32'(err_flag), 32'h1);

    // Simultaneous read and write: read wins, write never issued.
    do_reset();
    check("rst_err_again", 32'(err_flag), 32'h0);
    wc0 = wr_cycles;
    req_read_en = 1'b1; req_write_en = 1'b1; req_address = 26'h0000055;
    req_writedata = 32'h0000_0077;
    step();
    req_read_en = 1'b0; req_write_en = 1'b0;
    check("both_read", 32'(avm_read), 32'h1);
    check("both_no_write", 32'(avm_write), 32'h0);
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
    step();
    avm_readdatavalid = 1'b0;
    check("both_valid", 32'(req_readvalid), 32'h1);
    steps(2);
    check("both_err_sticky", 32'(err_flag), 32'h1);
    check("both_wr_cycles", 32'(wr_cycles - wc0), 32'h0);

    // Write request arriving while a read is in flight is ignored.
    do_reset();
    wc0 = wr_cycles;
    req_read_en = 1'b1; req_address = 26'h0000040; avm_waitrequest = 1'b1;
    step();
    req_read_en = 1'b0; req_write_en = 1'b1;
    step();
    req_write_en = 1'b0; avm_waitrequest = 1'b0;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h0000_0009;
    step();
    avm_readdatavalid = 1'b0;
    check("busy_req_valid", 32'(req_readvalid), 32'h1);
    check("busy_req_err", 32'(err_flag), 32'h1);
    steps(2);
    check("busy_req_no_write", 32'(wr_cycles - wc0), 32'h0);

    // Read timeout, then a normal read straight after.
    do_reset();
    req_read_en = 1'b1; req_address = 26'h0000020;
    step();
    req_read_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (req_readvalid === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
    check("to_rd_latency", 32'(lat), 32'(TO));
    check("to_rd_data", req_readdata, 32'hDEADBEEF);
    check("to_rd_err", 32'(err_flag), 32'h1);
    req_read_en = 1'b1; req_address = 26'h0000030;
    step();
    req_read_en = 1'b0;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h600D_600D;
    step();
    avm_readdatavalid = 1'b0;
    check("after_to_valid", 32'(req_readvalid), 32'h1);
    check("after_to_data", req_readdata, 32'h600D_600D);
    step();

    // Write timeout under permanent waitrequest.
    req_write_en = 1'b1; req_address = 26'h0000031; req_writedata = 32'h0000_0005;
    avm_waitrequest = 1'b1;
    step();
    req_write_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (req_write_done === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
    check("to_wr_latency", 32'(lat), 32'(TO));
    avm_waitrequest = 1'b0;
    steps(3);
    check("to_wr_idle", 32'(req_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
